vad_adaptive: RTL and testbench
===============================

Name: vad_adaptive

Overview:
- Parametrised successor to the fixed-threshold voice activity detector, sitting between the audio sample source and the circular capture buffer.
- Computes per-frame energy and zero-crossing count, IIR-smooths the energy and tracks an adaptive noise floor.
- Drives a four-state onset/speech/hangover FSM that raises speech_detected and emits start/end pulses for the buffer controller.

Parameters:
- DATA_W, 16: signed sample width.
- FRAME_LEN, 160: samples per analysis frame (10 ms at 16 kHz); must be ≥2.
- ENERGY_W, 40: width of energy, smoothed, floor and threshold datapaths.
- ALPHA_SHIFT, 3: smoother update, sm += (frame − sm) >>> ALPHA_SHIFT; 0 means sm = frame.
- NF_SHIFT, 6: noise-floor rise rate.
- NF_INIT, 100000: noise floor value after reset.
- NF_MIN, 1000: lower clamp on the noise floor.
- ON_MULT, 4: thr_on = noise_floor × ON_MULT.
- OFF_MULT, 2: thr_off = noise_floor × OFF_MULT; requires OFF_MULT ≤ ON_MULT.
- ONSET_FRAMES, 2: consecutive hot frames needed to declare speech; ≥1.
- HANGOVER_FRAMES, 30: quiet frames tolerated before speech ends; 0 allowed.
- ZCR_MAX, 80: frames with zcr above this are never hot (fricative/noise gate).

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- audio_in, input, DATA_W: signed two's-complement sample.
- sample_valid, input, 1: one-cycle strobe. Minimum spacing is 4 clk between strobes.
- frame_valid, output, 1: one-cycle pulse when frame_energy and frame_zcr update.
- frame_energy, output, ENERGY_W: sum of squares of the last frame, saturating.
- frame_zcr, output, 16: zero crossings counted in the last frame.
- smoothed_energy, output, ENERGY_W: IIR-smoothed frame energy.
- noise_floor, output, ENERGY_W: adaptive noise estimate.
- speech_detected, output, 1: high in SPEECH and HANGOVER.
- speech_start, output, 1: one-cycle pulse on ONSET→SPEECH or SILENCE→SPEECH.
- speech_end, output, 1: one-cycle pulse on entry to SILENCE from SPEECH or HANGOVER.

Behaviour:
- Reset values: all outputs 0 except noise_floor = NF_INIT. FSM = SILENCE, all counters 0, last_sign = 0. Reset mid-speech drops speech_detected immediately and does not emit speech_end.
- Accumulation: on each sample_valid, acc += audio_in² (signed square, saturating at 2^ENERGY_W−1) and the sample index increments. The sample with index FRAME_LEN−1 is included in its frame. That cycle is T, and acc and the index clear for the next frame.
- ZCR: a crossing counts when audio_in ≠ 0 and its sign differs from last_sign. Zero samples leave last_sign unchanged. last_sign persists across frames; the crossing count is per frame and saturates at 16'hFFFF.
- T+1: frame_energy and frame_zcr are registered and frame_valid pulses.
- T+2, smoother: smoothed_energy updates per the ALPHA_SHIFT rule using signed difference arithmetic; the result never goes negative.
- T+2, noise floor: updates only if state = SILENCE and frame_energy ≤ thr_on (thr_on computed from the pre-update floor).
  - frame < nf: nf ← frame.
  - otherwise: nf ← nf + ((frame − nf) >> NF_SHIFT).
  - In both cases nf is then clamped to ≥ NF_MIN.
- Thresholds: products saturate at 2^ENERGY_W−1.
- T+3 decision, using the updated smoothed_energy and noise_floor:
  - hot = smoothed_energy > thr_on AND frame_zcr ≤ ZCR_MAX.
  - cold = smoothed_energy < thr_off.
- FSM transitions, evaluated once per frame at T+3:
  - SILENCE: hot goes to ONSET with cnt = 1. If ONSET_FRAMES = 1, go straight to SPEECH and pulse speech_start.
  - ONSET: hot increments cnt; when cnt reaches ONSET_FRAMES, go to SPEECH and pulse speech_start. Not hot returns to SILENCE with no pulse.
  - SPEECH: cold goes to HANGOVER with hcnt = HANGOVER_FRAMES. If HANGOVER_FRAMES = 0, go directly to SILENCE and pulse speech_end. Otherwise stay.
  - HANGOVER: smoothed_energy ≥ thr_off returns to SPEECH with no pulse. Otherwise, if hcnt = 1, go to SILENCE and pulse speech_end; else hcnt−1.
- Outputs: speech_detected, speech_start and speech_end are registered and change at T+3. speech_start and speech_end are never high in the same cycle.

Test Plan:
- Reset check: assert rst_n low mid-frame → all outputs 0, noise_floor = 100000; after release, the first frame_valid occurs 1 clk after the 160th strobe.
- Floor tracking (ALPHA_SHIFT=0): 5 frames of constant 10 → frame_energy = 16000 each, noise_floor = 16000 after frame 1, speech_detected stays 0.
- Onset: after the floor is at 16000, feed constant 100 (energy 1,600,000, zcr 0) → ONSET after frame 1, speech_start at T+3 of frame 2, noise_floor stays 16000.
- Debounce: one loud frame between quiet frames → no speech_start, FSM returns to SILENCE.
- Hangover (HANGOVER_FRAMES=3): in speech, feed constant 10 frames → speech_end and speech_detected fall at T+3 of the 4th quiet frame. A loud frame at quiet frame 2 returns to SPEECH with no pulses.
- ZCR gate: alternating +100/−100 (zcr 159 > 80) → never hot, speech_detected stays 0. Also verify frame_energy saturation with full-scale input at ENERGY_W=32.

Source files
------------

// File: rtl/vad_adaptive.sv
// Adaptive voice activity detector. Accumulates per-frame energy and
// zero-crossing count, IIR-smooths the energy, tracks a noise floor while
// silent, and runs an onset/speech/hangover FSM with start/end pulses.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_SILENCE  | no speech; noise floor may adapt
// ST_ONSET    | counting consecutive hot frames before declaring speech
// ST_SPEECH   | speech active
// ST_HANGOVER | quiet frames seen; counting down before declaring silence
//
// Frame pipeline: T = last sample strobe, T+1 frame results, T+2 smoother
// and floor, T+3 FSM outputs. Strobe spacing of 4 clk keeps stages disjoint.
module vad_adaptive #(
    parameter int DATA_W          = 16,
    parameter int FRAME_LEN       = 160,
    parameter int ENERGY_W        = 40,
    parameter int ALPHA_SHIFT     = 3,
    parameter int NF_SHIFT        = 6,
    parameter int NF_INIT         = 100000,
    parameter int NF_MIN          = 1000,
    parameter int ON_MULT         = 4,
    parameter int OFF_MULT        = 2,
    parameter int ONSET_FRAMES    = 2,
    parameter int HANGOVER_FRAMES = 30,
    parameter int ZCR_MAX         = 80
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   audio_in,
    input  logic                sample_valid,
    output logic                frame_valid,
    output logic [ENERGY_W-1:0] frame_energy,
    output logic [15:0]         frame_zcr,
    output logic [ENERGY_W-1:0] smoothed_energy,
    output logic [ENERGY_W-1:0] noise_floor,
    output logic                speech_detected,
    output logic                speech_start,
    output logic                speech_end
);

    localparam int SQ_W  = 2 * DATA_W;
    localparam int SUM_W = ((ENERGY_W > SQ_W) ? ENERGY_W : SQ_W) + 1;
    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam int DIF_W = ENERGY_W + 2;
    localparam logic [ENERGY_W-1:0] E_MAX     = '1;
    localparam logic [ENERGY_W-1:0] NF_MIN_V  = ENERGY_W'(NF_MIN);
    localparam logic [ENERGY_W-1:0] NF_INIT_V = ENERGY_W'(NF_INIT);

    typedef enum logic [1:0] {
        ST_SILENCE,
        ST_ONSET,
        ST_SPEECH,
        ST_HANGOVER
    } state_t;

    logic [ENERGY_W-1:0] acc_q;
    logic [IDX_W-1:0]    idx_q;
    logic [15:0]         zcr_q;
    logic                last_sign_q;
    logic                frame_valid_q;
    logic [ENERGY_W-1:0] frame_energy_q;
    logic [15:0]         frame_zcr_q;
    logic                dec_q;
    logic [ENERGY_W-1:0] sm_q, sm_d;
    logic [ENERGY_W-1:0] nf_q, nf_d;
    state_t              state_q, state_d;
    logic [15:0]         onset_cnt_q, onset_cnt_d;
    logic [15:0]         hang_cnt_q, hang_cnt_d;
    logic                start_q, start_d;
    logic                end_q, end_d;

    // Saturating multiply used for the on/off thresholds.
    function automatic logic [ENERGY_W-1:0] sat_mul(input logic [ENERGY_W-1:0] a, input int m);
        logic [ENERGY_W+31:0] p;
        p = {32'd0, a} * (ENERGY_W + 32)'(m);
        return (p > {32'd0, E_MAX}) ? E_MAX : p[ENERGY_W-1:0];
    endfunction

    logic signed [SQ_W-1:0] sq_s;
    logic [SUM_W-1:0]       acc_sum;
    logic [ENERGY_W-1:0]    acc_sat;
    logic                   crossing;
    logic [15:0]            zcr_next;
    logic                   frame_end;
    logic [ENERGY_W-1:0]    thr_on, thr_off;
    logic signed [DIF_W-1:0] sm_diff, sm_step, sm_sum;
    logic [ENERGY_W-1:0]    nf_rise, nf_cand;
    logic                   nf_upd;
    logic                   hot, cold;

    assign sq_s      = $signed(audio_in) * $signed(audio_in);
    assign acc_sum   = SUM_W'(acc_q) + SUM_W'($unsigned(sq_s));
    assign acc_sat   = (acc_sum > SUM_W'(E_MAX)) ? E_MAX : acc_sum[ENERGY_W-1:0];
    // Zero samples carry no sign information, so they never count as crossings.
    assign crossing  = (audio_in != '0) && (audio_in[DATA_W-1] != last_sign_q);
    assign zcr_next  = (crossing && (zcr_q != 16'hFFFF)) ? zcr_q + 16'd1 : zcr_q;
    assign frame_end = sample_valid && (idx_q == IDX_W'(FRAME_LEN - 1));

    assign thr_on  = sat_mul(nf_q, ON_MULT);
    assign thr_off = sat_mul(nf_q, OFF_MULT);

    // Arithmetic shift floors toward -inf, so the sum can never undershoot
    // the frame value; the clamps are belt and braces.
    assign sm_diff = $signed({2'b00, frame_energy_q}) - $signed({2'b00, sm_q});
    assign sm_step = sm_diff >>> ALPHA_SHIFT;
    assign sm_sum  = $signed({2'b00, sm_q}) + sm_step;
    assign sm_d    = sm_sum[DIF_W-1] ? '0 : (sm_sum[ENERGY_W] ? E_MAX : sm_sum[ENERGY_W-1:0]);

    assign nf_rise = nf_q + ((frame_energy_q - nf_q) >> NF_SHIFT);
    assign nf_cand = (frame_energy_q < nf_q) ? frame_energy_q : nf_rise;
    assign nf_d    = (nf_cand < NF_MIN_V) ? NF_MIN_V : nf_cand;
    assign nf_upd  = frame_valid_q && (state_q == ST_SILENCE) && (frame_energy_q <= thr_on);

    assign hot  = (sm_q > thr_on) && (frame_zcr_q <= 16'(ZCR_MAX));
    assign cold = sm_q < thr_off;

    // Per-sample energy and crossing accumulation; last_sign spans frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            idx_q       <= '0;
            zcr_q       <= '0;
            last_sign_q <= 1'b0;
        end else if (sample_valid) begin
            if (frame_end) begin
                acc_q <= '0;
                idx_q <= '0;
                zcr_q <= '0;
            end else begin
                acc_q <= acc_sat;
                idx_q <= idx_q + IDX_W'(1);
                zcr_q <= zcr_next;
            end
            if (audio_in != '0) last_sign_q <= audio_in[DATA_W-1];
        end
    end

    // Frame result registers, valid the cycle after the closing sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid_q  <= 1'b0;
            frame_energy_q <= '0;
            frame_zcr_q    <= '0;
        end else begin
            frame_valid_q <= frame_end;
            if (frame_end) begin
                frame_energy_q <= acc_sat;
                frame_zcr_q    <= zcr_next;
            end
        end
    end

    // Smoother and noise-floor update one cycle after frame results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= 1'b0;
            sm_q  <= '0;
            nf_q  <= NF_INIT_V;
        end else begin
            dec_q <= frame_valid_q;
            if (frame_valid_q) sm_q <= sm_d;
            if (nf_upd) nf_q <= nf_d;
        end
    end

    // FSM state and registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SILENCE;
            onset_cnt_q <= '0;
            hang_cnt_q  <= '0;
            start_q     <= 1'b0;
            end_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            onset_cnt_q <= onset_cnt_d;
            hang_cnt_q  <= hang_cnt_d;
            start_q     <= start_d;
            end_q       <= end_d;
        end
    end

    // Once-per-frame decision using the freshly updated smoother and floor.
    always_comb begin
        state_d     = state_q;
        onset_cnt_d = onset_cnt_q;
        hang_cnt_d  = hang_cnt_q;
        start_d     = 1'b0;
        end_d       = 1'b0;
        if (dec_q) begin
            unique case (state_q)
                ST_SILENCE: begin
                    if (hot) begin
                        if (ONSET_FRAMES <= 1) begin
                            state_d     = ST_SPEECH;
                            onset_cnt_d = '0;
                            start_d     = 1'b1;
                        end else begin
                            state_d     = ST_ONSET;
                            onset_cnt_d = 16'd1;
                        end
                    end
                end
                ST_ONSET: begin
                    if (hot) begin
                        if (onset_cnt_q + 16'd1 >= 16'(ONSET_FRAMES)) begin
                            state_d     = ST_SPEECH;
                            onset_cnt_d = '0;
                            start_d     = 1'b1;
                        end else begin
                            onset_cnt_d = onset_cnt_q + 16'd1;
                        end
                    end else begin
                        state_d     = ST_SILENCE;
                        onset_cnt_d = '0;
                    end
                end
                ST_SPEECH: begin
                    if (cold) begin
                        if (HANGOVER_FRAMES == 0) begin
                            state_d = ST_SILENCE;
                            end_d   = 1'b1;
                        end else begin
                            state_d    = ST_HANGOVER;
                            hang_cnt_d = 16'(HANGOVER_FRAMES);
                        end
                    end
                end
                ST_HANGOVER: begin
                    if (sm_q >= thr_off) begin
                        state_d    = ST_SPEECH;
                        hang_cnt_d = '0;
                    end else if (hang_cnt_q <= 16'd1) begin
                        state_d    = ST_SILENCE;
                        hang_cnt_d = '0;
                        end_d      = 1'b1;
                    end else begin
                        hang_cnt_d = hang_cnt_q - 16'd1;
                    end
                end
                default: state_d = ST_SILENCE;
            endcase
        end
    end

    assign frame_valid     = frame_valid_q;
    assign frame_energy    = frame_energy_q;
    assign frame_zcr       = frame_zcr_q;
    assign smoothed_energy = sm_q;
    assign noise_floor     = nf_q;
    assign speech_detected = (state_q == ST_SPEECH) || (state_q == ST_HANGOVER);
    assign speech_start    = start_q;
    assign speech_end      = end_q;

endmodule

// File: tb/tb_vad_adaptive.sv
// Bench for vad_adaptive: a table of whole-frame stimuli with expected frame
// results, queued when a frame is driven and checked by a monitor when
// frame_valid fires; reset sequences are written out by hand.
module tb_vad_adaptive;

    typedef struct {
        int     kind;   // 0 = constant amplitude, 1 = alternating +amp/-amp
        int     amp;
        longint e40;    // expected frame energy (and smoothed, alpha shift 0), 40-bit DUT
        longint e32;    // same for 32-bit DUT
        int     zcr;
        longint nf;
        int     det;
        int     st;
        int     en;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] audio = '0;
    logic        sv = 1'b0;

    logic        fv, det, st, en;
    logic [39:0] fe, sm, nf;
    logic [15:0] zcr;
    logic        fv32, det32, st32, en32;
    logic [31:0] fe32, sm32, nf32;
    logic [15:0] zcr32;

    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;
    longint last_strobe_cyc = 0;
    int     sent = 0;
    int     seen = 0;
    int     cur_id = 0;
    vec_t   q[$];
    vec_t   tbl[23];

    vad_adaptive #(.ALPHA_SHIFT(0), .HANGOVER_FRAMES(3)) dut (
        .clk(clk), .rst_n(rst_n), .audio_in(audio), .sample_valid(sv),
        .frame_valid(fv), .frame_energy(fe), .frame_zcr(zcr),
        .smoothed_energy(sm), .noise_floor(nf),
        .speech_detected(det), .speech_start(st), .speech_end(en)
    );

    vad_adaptive #(.ENERGY_W(32), .ALPHA_SHIFT(0), .HANGOVER_FRAMES(3)) dut32 (
        .clk(clk), .rst_n(rst_n), .audio_in(audio), .sample_valid(sv),
        .frame_valid(fv32), .frame_energy(fe32), .frame_zcr(zcr32),
        .smoothed_energy(sm32), .noise_floor(nf32),
        .speech_detected(det32), .speech_start(st32), .speech_end(en32)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int id, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (frame %0d): got %0d expected %0d", name, id, act, exp);
        end
    endtask

    task automatic drive_frame(input int kind, input int amp, input int nsamp);
        for (int i = 0; i < nsamp; i++) begin
            @(negedge clk);
            if (kind == 1 && (i % 2) == 1) audio = 16'(-amp);
            else audio = 16'(amp);
            sv = 1'b1;
            last_strobe_cyc = cyc;
            @(negedge clk);
            sv = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int t;
        q.push_back(v);
        sent++;
        drive_frame(v.kind, v.amp, 160);
        t = 0;
        while (seen < sent && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (seen < sent) begin
            chk("frame_valid_timeout", cur_id, 0, 1);
            q.delete();
            seen = sent;
        end
        cur_id++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_frame_valid"}, cur_id, longint'(fv), 0);
        chk({tag, "_frame_energy"}, cur_id, longint'(fe), 0);
        chk({tag, "_frame_zcr"}, cur_id, longint'(zcr), 0);
        chk({tag, "_smoothed"}, cur_id, longint'(sm), 0);
        chk({tag, "_noise_floor"}, cur_id, longint'(nf), 100000);
        chk({tag, "_noise_floor32"}, cur_id, longint'(nf32), 100000);
        chk({tag, "_speech_detected"}, cur_id, longint'(det), 0);
        chk({tag, "_speech_start"}, cur_id, longint'(st), 0);
        chk({tag, "_speech_end"}, cur_id, longint'(en), 0);
    endtask

    // Monitor: pops an expectation on each frame_valid and follows the frame
    // through the T+1..T+4 pipeline stages.
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (fv) begin
                if (q.size() == 0) begin
                    chk("unexpected_frame_valid", cur_id, 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("fv_latency", cur_id, cyc - last_strobe_cyc, 1);
                    chk("frame_valid32", cur_id, longint'(fv32), 1);
                    chk("frame_energy", cur_id, longint'(fe), e.e40);
                    chk("frame_energy32", cur_id, longint'(fe32), e.e32);
                    chk("frame_zcr", cur_id, longint'(zcr), e.zcr);
                    chk("frame_zcr32", cur_id, longint'(zcr32), e.zcr);
                    @(negedge clk);
                    chk("frame_valid_pulse", cur_id, longint'(fv), 0);
                    chk("smoothed", cur_id, longint'(sm), e.e40);
                    chk("smoothed32", cur_id, longint'(sm32), e.e32);
                    chk("noise_floor", cur_id, longint'(nf), e.nf);
                    chk("noise_floor32", cur_id, longint'(nf32), e.nf);
                    @(negedge clk);
                    chk("speech_detected", cur_id, longint'(det), e.det);
                    chk("speech_start", cur_id, longint'(st), e.st);
                    chk("speech_end", cur_id, longint'(en), e.en);
                    chk("speech_detected32", cur_id, longint'(det32), e.det);
                    chk("speech_start32", cur_id, longint'(st32), e.st);
                    chk("speech_end32", cur_id, longint'(en32), e.en);
                    @(negedge clk);
                    chk("start_pulse_width", cur_id, longint'(st), 0);
                    chk("end_pulse_width", cur_id, longint'(en), 0);
                    seen++;
                end
            end
        end
    end

    initial begin
        vec_t post;
        // floor tracking at constant 10 (energy 16000)
        tbl[0]  = '{0, 10, 16000, 16000, 0, 16000, 0, 0, 0};
        tbl[1]  = '{0, 10, 16000, 16000, 0, 16000, 0, 0, 0};
        tbl[2]  = '{0, 10, 16000, 16000, 0, 16000, 0, 0, 0};
        tbl[3]  = '{0, 10, 16000, 16000, 0, 16000, 0, 0, 0};
        tbl[4]  = '{0, 10, 16000, 16000, 0, 16000, 0, 0, 0};
        // onset: two loud frames
        tbl[5]  = '{0, 100, 1600000, 1600000, 0, 16000, 0, 0, 0};
        tbl[6]  = '{0, 100, 1600000, 1600000, 0, 16000, 1, 1, 0};
        // hangover entry, loud frame back to speech, then 4 quiet frames
        tbl[7]  = '{0, 10, 16000, 16000, 0, 16000, 1, 0, 0};
        tbl[8]  = '{0, 100, 1600000, 1600000, 0, 16000, 1, 0, 0};
        tbl[9]  = '{0, 10, 16000, 16000, 0, 16000, 1, 0, 0};
        tbl[10] = '{0, 10, 16000, 16000, 0, 16000, 1, 0, 0};
        tbl[11] = '{0, 10, 16000, 16000, 0, 16000, 1, 0, 0};
        tbl[12] = '{0, 10, 16000, 16000, 0, 16000, 0, 0, 1};
        // debounce: single loud frame between quiet ones
        tbl[13] = '{0, 100, 1600000, 1600000, 0, 16000, 0, 0, 0};
        tbl[14] = '{0, 10, 16000, 16000, 0, 16000, 0, 0, 0};
        tbl[15] = '{0, 10, 16000, 16000, 0, 16000, 0, 0, 0};
        // zcr gate
        tbl[16] = '{1, 100, 1600000, 1600000, 159, 16000, 0, 0, 0};
        tbl[17] = '{1, 100, 1600000, 1600000, 160, 16000, 0, 0, 0};
        // energy exactly at thr_on: floor rises by (64000-16000)>>6 = 750
        tbl[18] = '{0, 20, 64000, 64000, 1, 16750, 0, 0, 0};
        tbl[19] = '{0, 10, 16000, 16000, 0, 16000, 0, 0, 0};
        // silence clamps floor to NF_MIN
        tbl[20] = '{0, 0, 0, 0, 0, 1000, 0, 0, 0};
        // full-scale negative: 160 * 2^30, 32-bit DUT saturates
        tbl[21] = '{0, -32768, 64'd171798691840, 64'd4294967295, 1, 1000, 0, 0, 0};
        tbl[22] = '{0, -32768, 64'd171798691840, 64'd4294967295, 0, 1000, 1, 1, 0};

        // power-on reset
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;

        // reset in the middle of a partial frame
        drive_frame(0, 100, 50);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midframe_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) run_vec(tbl[i]);

        // reset while in SPEECH, partway through a frame
        chk("pre_reset_in_speech", cur_id, longint'(det), 1);
        drive_frame(0, 10, 40);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("speech_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        post = '{0, 10, 16000, 16000, 0, 16000, 0, 0, 0};
        run_vec(post);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
